// File: rtl/fir_decim_param_if.sv
// Sample/coefficient bus for fir_decim_param.
//  master : the upstream stage (drives samples, clear and coefficient writes)
//  slave  : the filter (returns filtered samples, valid pulse and overflow flag)
// Signals
//  clr_i        synchronous clear of delay line, pipeline and phase counter
//  valid_i      data_i valid this cycle
//  data_i       signed input sample, DATA_W bits
//  coef_we_i    coefficient write strobe
//  coef_addr_i  tap index to write, $clog2(TAPS) bits
//  coef_data_i  signed coefficient value, COEF_W bits
//  valid_o      single-cycle pulse per output sample
//  data_o       signed output sample, DATA_W bits
//  ovf_o        high with valid_o when data_o was saturated
interface fir_decim_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 17
);
  localparam int AW = $clog2(TAPS);

  logic              clr_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              coef_we_i;
  logic [AW-1:0]     coef_addr_i;
  logic [COEF_W-1:0] coef_data_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ovf_o;

  modport master (
    output clr_i, valid_i, data_i, coef_we_i, coef_addr_i, coef_data_i,
    input  valid_o, data_o, ovf_o
  );

  modport slave (
    input  clr_i, valid_i, data_i, coef_we_i, coef_addr_i, coef_data_i,
    output valid_o, data_o, ovf_o
  );
endinterface

// File: rtl/fir_decim_param.sv
// Direct-form FIR filter with integer decimation, rounding and saturation.
// Pipeline: delay line (E0) -> per-tap products (E1) -> tap sum (E2)
//           -> round/shift/clamp to output (E3). valid_o follows the
//           accepting edge by 3 clocks.
// Ports
//  clk   system clock, rising edge
//  rst   asynchronous reset, active low
//  bus   fir_decim_param_if.slave (samples, clear, coefficient writes, outputs)

// One tap: delay-line element, coefficient register and product register.
module fir_tap #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter logic [COEF_W-1:0] RST_COEF = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     shift,
  input  logic                     coef_we,
  input  logic [DATA_W-1:0]        din,
  input  logic [COEF_W-1:0]        coef_d,
  output logic [DATA_W-1:0]        dout,
  output logic [DATA_W+COEF_W-1:0] prod
);
  localparam int PW = DATA_W + COEF_W;

  logic [COEF_W-1:0] h;

  // Coefficients survive clr; only reset restores the default.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         h <= RST_COEF;
    else if (coef_we) h <= coef_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      prod <= '0;
    end else if (clr) begin
      dout <= '0;
      prod <= '0;
    end else begin
      if (shift) dout <= din;
      prod <= PW'($signed(h)) * PW'($signed(dout));
    end
  end
endmodule

module fir_decim_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 17,
  parameter int DECIM     = 1,
  parameter int OUT_SHIFT = 15
) (
  input logic             clk,
  input logic             rst,
  fir_decim_param_if.slave bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int PW     = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int STAGES = 3;
  localparam int RSH    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(DECIM - 1);
  localparam logic [COEF_W-1:0]       CENTRE  = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   RND     = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RSH) : '0;
  localparam logic signed [ACC_W:0]   MAXV    = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   MINV    = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [TAPS-1:0][DATA_W-1:0] buff;
  logic [TAPS-1:0][DATA_W-1:0] tap_in;
  logic [TAPS-1:0][PW-1:0]     prod;
  logic [PH_W-1:0]             phase;
  logic [STAGES:0]             vld_pipe;  // [0]=t0 [1]=t1 [2]=t2 [3]=valid_o
  logic                        accept;

  logic signed [ACC_W-1:0] acc, sum_q;
  logic signed [ACC_W:0]   rsum, rshift;
  logic [DATA_W-1:0]       clamped, data_q;
  logic                    sat, ovf_q;

  // clr drops a simultaneous sample.
  assign accept = bus.valid_i & ~bus.clr_i;
  assign tap_in = {buff[TAPS-2:0], bus.data_i};

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_tap #(
      .DATA_W  (DATA_W),
      .COEF_W  (COEF_W),
      .RST_COEF((k == TAPS/2) ? CENTRE : '0)
    ) u_tap (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.clr_i),
      .shift  (accept),
      .coef_we(bus.coef_we_i && (bus.coef_addr_i == AW'(k))),
      .din    (tap_in[k]),
      .coef_d (bus.coef_data_i),
      .dout   (buff[k]),
      .prod   (prod[k])
    );
  end

  // Phase advances only on accepted samples, so valid_i gaps do not move it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           phase <= '0;
    else if (bus.clr_i) phase <= '0;
    else if (accept)    phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  end

  // Stages 1-3 always advance; only t0 depends on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           vld_pipe <= '0;
    else if (bus.clr_i) vld_pipe <= '0;
    else                vld_pipe <= {vld_pipe[STAGES-1:0], accept & (phase == '0)};
  end

  // Accumulator is wide enough that the tap sum cannot wrap.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'($signed(prod[k]));
  end

  // One extra bit keeps the rounding add from wrapping at the extremes.
  assign rsum   = $signed({sum_q[ACC_W-1], sum_q}) + RND;
  assign rshift = rsum >>> OUT_SHIFT;

  always_comb begin
    sat     = 1'b0;
    clamped = rshift[DATA_W-1:0];
    if (rshift > MAXV) begin
      sat     = 1'b1;
      clamped = MAXV[DATA_W-1:0];
    end else if (rshift < MINV) begin
      sat     = 1'b1;
      clamped = MINV[DATA_W-1:0];
    end
  end

  // data_o holds between pulses and across clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.clr_i) begin
      sum_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q <= acc;
      if (vld_pipe[STAGES-1]) data_q <= clamped;
      ovf_q <= vld_pipe[STAGES-1] & sat;
    end
  end

  assign bus.valid_o = vld_pipe[STAGES];
  assign bus.data_o  = data_q;
  assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_fir_decim_param.sv
// Directed bench for fir_decim_param: a 17-tap DECIM=1 instance and an
// 8-tap DECIM=4 instance sharing clock and reset.
module tb_fir_decim_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  fir_decim_param_if #(.DATA_W(16), .COEF_W(16), .TAPS(17)) bus1 ();
  fir_decim_param_if #(.DATA_W(16), .COEF_W(16), .TAPS(8))  bus2 ();

  fir_decim_param #(.DATA_W(16), .COEF_W(16), .TAPS(17), .DECIM(1), .OUT_SHIFT(15))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fir_decim_param #(.DATA_W(16), .COEF_W(16), .TAPS(8), .DECIM(4), .OUT_SHIFT(15))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int h_tab [17] = '{83, 188, 481, 1030, 1818, 2734, 3600, 4222, 4448,
                     4222, 3600, 2734, 1818, 1030, 481, 188, 83};
  int y_tab [17] = '{3, 6, 15, 31, 55, 83, 110, 129, 136,
                     129, 110, 83, 55, 31, 15, 6, 3};

  // Captured outputs {ovf, data}
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  always @(negedge clk) begin
    if (bus1.valid_o) q1.push_back({bus1.ovf_o, bus1.data_o});
    if (bus2.valid_o) q2.push_back({bus2.ovf_o, bus2.data_o});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send1(input int d);
    bus1.valid_i = 1'b1;
    bus1.data_i  = 16'(d);
    tick(1);
    bus1.valid_i = 1'b0;
    bus1.data_i  = '0;
  endtask

  task automatic send2(input int d);
    bus2.valid_i = 1'b1;
    bus2.data_i  = 16'(d);
    tick(1);
    bus2.valid_i = 1'b0;
    bus2.data_i  = '0;
  endtask

  task automatic wcoef1(input int a, input int v);
    bus1.coef_we_i   = 1'b1;
    bus1.coef_addr_i = 5'(a);
    bus1.coef_data_i = 16'(v);
    tick(1);
    bus1.coef_we_i   = 1'b0;
  endtask

  task automatic wcoef2(input int a, input int v);
    bus2.coef_we_i   = 1'b1;
    bus2.coef_addr_i = 3'(a);
    bus2.coef_data_i = 16'(v);
    tick(1);
    bus2.coef_we_i   = 1'b0;
  endtask

  // Impulse of 1000 followed by 16 zeros, back to back, then drain.
  task automatic impulse1();
    q1.delete();
    send1(1000);
    repeat (16) send1(0);
    tick(5);
  endtask

  task automatic test_reset();
    logic [16:0] got;
    logic [16:0] exp;
    rst = 1'b0;
    tick(2);
    vectors++;
    if (bus1.valid_o !== 1'b0 || bus1.data_o !== 16'd0 || bus1.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%0d o=%b want v=0 d=0 o=0",
               bus1.valid_o, bus1.data_o, bus1.ovf_o);
    end
    rst = 1'b1;
    tick(2);
    q1.delete();
    send1(1000);
    // valid_o must rise exactly 3 clocks after the accepting edge
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (bus1.valid_o !== (c == 3)) begin
        errors++;
        $display("FAIL latency_c%0d: got valid_o=%b want %b", c, bus1.valid_o, c == 3);
      end
      if (c < 3) tick(1);
    end
    repeat (8) send1(0);
    tick(5);
    vectors++;
    if (q1.size() !== 9) begin
      errors++;
      $display("FAIL t1_count: got %0d want 9", q1.size());
    end
    for (int i = 0; i < 9; i++) begin
      got = (i < q1.size()) ? q1[i] : 17'h1ffff;
      exp = (i == 8) ? {1'b0, 16'd1000} : 17'd0;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL t1_out%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_coef_write();
    logic [16:0] got;
    logic [16:0] exp;
    wcoef1(8, -16384);
    wcoef1(25, 12345);  // out of range, must be ignored
    tick(2);
    impulse1();
    vectors++;
    if (q1.size() !== 17) begin
      errors++;
      $display("FAIL t6_count: got %0d want 17", q1.size());
    end
    for (int i = 0; i < 17; i++) begin
      got = (i < q1.size()) ? q1[i] : 17'h1ffff;
      exp = (i == 8) ? {1'b0, 16'(-500)} : 17'd0;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL t6_out%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_impulse();
    logic [16:0] got;
    logic [16:0] exp;
    for (int k = 0; k < 17; k++) wcoef1(k, h_tab[k]);
    tick(1);
    impulse1();
    vectors++;
    if (q1.size() !== 17) begin
      errors++;
      $display("FAIL t2_count: got %0d want 17", q1.size());
    end
    for (int i = 0; i < 17; i++) begin
      got = (i < q1.size()) ? q1[i] : 17'h1ffff;
      exp = {1'b0, 16'(y_tab[i])};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL t2_out%0d: got %h want %h", i, got, exp);
      end
    end
    tick(4);
    vectors++;
    if (bus1.data_o !== 16'd3 || bus1.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t2_hold: got d=%0d v=%b want d=3 v=0", bus1.data_o, bus1.valid_o);
    end
  endtask

  task automatic test_clr();
    logic [16:0] got;
    logic [16:0] exp;
    q1.delete();
    send1(3000);
    send1(-2000);
    send1(7000);
    bus1.clr_i   = 1'b1;
    bus1.valid_i = 1'b1;  // dropped: clr wins
    bus1.data_i  = 16'd5000;
    tick(1);
    bus1.clr_i   = 1'b0;
    bus1.valid_i = 1'b0;
    bus1.data_i  = '0;
    tick(6);
    vectors++;
    if (q1.size() !== 0) begin
      errors++;
      $display("FAIL clr_stale: got %0d pulses want 0", q1.size());
    end
    vectors++;
    if (bus1.data_o !== 16'd3) begin
      errors++;
      $display("FAIL clr_hold: got %0d want 3", bus1.data_o);
    end
    impulse1();
    vectors++;
    if (q1.size() !== 17) begin
      errors++;
      $display("FAIL clr_count: got %0d want 17", q1.size());
    end
    for (int i = 0; i < 17; i++) begin
      got = (i < q1.size()) ? q1[i] : 17'h1ffff;
      exp = {1'b0, 16'(y_tab[i])};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clr_out%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [16:0] got;
    logic [16:0] exp;
    q1.delete();
    send1(3000);
    send1(4000);
    bus1.valid_i = 1'b1;
    bus1.data_i  = 16'd6000;
    #2 rst = 1'b0;
    tick(2);
    rst = 1'b1;
    bus1.valid_i = 1'b0;
    bus1.data_i  = '0;
    tick(6);
    vectors++;
    if (q1.size() !== 0 || bus1.data_o !== 16'd0) begin
      errors++;
      $display("FAIL rst_stale: got %0d pulses d=%0d want 0 pulses d=0", q1.size(), bus1.data_o);
    end
    // Coefficients are back to the near-identity default
    impulse1();
    vectors++;
    if (q1.size() !== 17) begin
      errors++;
      $display("FAIL rst_count: got %0d want 17", q1.size());
    end
    for (int i = 0; i < 17; i++) begin
      got = (i < q1.size()) ? q1[i] : 17'h1ffff;
      exp = (i == 8) ? {1'b0, 16'd1000} : 17'd0;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rst_out%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) wcoef1(k, 32767);
    tick(1);
    q1.delete();
    repeat (17) send1(32767);
    repeat (17) send1(-32768);
    tick(5);
    vectors++;
    if (q1.size() !== 34) begin
      errors++;
      $display("FAIL t3_count: got %0d want 34", q1.size());
    end
    if (q1.size() == 34) begin
      // single full-scale tap: 32766, just below the rail
      vectors++;
      if (q1[0] !== {1'b0, 16'd32766}) begin
        errors++;
        $display("FAIL t3_first: got %h want %h", q1[0], {1'b0, 16'd32766});
      end
      vectors++;
      if (q1[16] !== {1'b1, 16'h7fff}) begin
        errors++;
        $display("FAIL t3_pos: got %h want %h", q1[16], {1'b1, 16'h7fff});
      end
      vectors++;
      if (q1[33] !== {1'b1, 16'h8000}) begin
        errors++;
        $display("FAIL t3_neg: got %h want %h", q1[33], {1'b1, 16'h8000});
      end
    end
  endtask

  task automatic test_decimation();
    logic [16:0] got;
    logic [16:0] exp;
    wcoef2(0, 16384);
    wcoef2(1, 8192);
    wcoef2(4, -16384);
    tick(1);
    q2.delete();
    for (int i = 0; i < 8; i++) begin
      send2(100 * (i + 1));
      tick($urandom_range(0, 3));
    end
    tick(6);
    vectors++;
    if (q2.size() !== 2) begin
      errors++;
      $display("FAIL t4_count: got %0d want 2", q2.size());
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < q2.size()) ? q2[i] : 17'h1ffff;
      exp = (i == 0) ? {1'b0, 16'd50} : {1'b0, 16'd300};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL t4_out%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    bus1.clr_i = 1'b0; bus1.valid_i = 1'b0; bus1.data_i = '0;
    bus1.coef_we_i = 1'b0; bus1.coef_addr_i = '0; bus1.coef_data_i = '0;
    bus2.clr_i = 1'b0; bus2.valid_i = 1'b0; bus2.data_i = '0;
    bus2.coef_we_i = 1'b0; bus2.coef_addr_i = '0; bus2.coef_data_i = '0;
    test_reset();
    test_coef_write();
    test_impulse();
    test_clr();
    test_rst_mid();
    test_saturation();
    test_decimation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
